// File: rtl/systolic_job_scheduler_if.sv
// Host-side job/done handshake bundle for the systolic job scheduler.
// The host drives descriptors, abort and done acceptance; the scheduler answers.
interface systolic_job_scheduler_if #(
    parameter int ID_W   = 4,
    parameter int TILE_W = 4
);
    logic              job_valid;
    logic              job_ready;
    logic [ID_W-1:0]   job_id;
    logic [TILE_W-1:0] job_tiles;
    logic              abort;
    logic              done_valid;
    logic [ID_W-1:0]   done_id;
    logic              done_ready;

    modport master (
        output job_valid, job_id, job_tiles, abort, done_ready,
        input  job_ready, done_valid, done_id
    );

    modport slave (
        input  job_valid, job_id, job_tiles, abort, done_ready,
        output job_ready, done_valid, done_id
    );
endinterface

// File: rtl/systolic_job_scheduler.sv
// Sequences an NxN weight-stationary array through host matmul jobs:
// one LOAD of the stationary A rows, then one skewed PROCESS pass per B tile.
typedef enum logic [1:0] {
    PASSTHROUGH = 2'd0,
    LOAD        = 2'd1,
    PROCESS     = 2'd2
} input_mux_t;

module systolic_job_scheduler #(
    parameter int  N      = 4,
    parameter int  TILE_W = 4,
    parameter int  ID_W   = 4,
    parameter int  ADDR_W = 8,
    localparam int LOG_N  = $clog2(N)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    systolic_job_scheduler_if.slave       host,
    input  logic                          acc_ready_i,
    output input_mux_t                    mode_o,
    output logic                          array_en_o,
    output logic                          a_rd_en_o,
    output logic [LOG_N-1:0]              a_rd_addr_o,
    output logic [N-1:0]                  b_rd_en_o,
    output logic [N-1:0][ADDR_W-1:0]      b_rd_addr_o,
    output logic [N-1:0]                  acc_valid_o,
    output logic                          busy_o
);

    localparam int T_W = $clog2(3*N - 1);
    localparam logic [T_W-1:0] T_LOAD_END = T_W'(N - 1);
    localparam logic [T_W-1:0] T_PROC_END = T_W'(3*N - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PROC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_r,  state_nx_s;
    logic [T_W-1:0]    t_r,      t_nx_s;
    logic [TILE_W-1:0] k_r,      k_nx_s;
    logic [TILE_W-1:0] tiles_r,  tiles_nx_s;
    logic [ID_W-1:0]   id_r,     id_nx_s;
    logic              in_proc_s;

    // State, counter and descriptor registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            t_r     <= '0;
            k_r     <= '0;
            tiles_r <= '0;
            id_r    <= '0;
        end else begin
            state_r <= state_nx_s;
            t_r     <= t_nx_s;
            k_r     <= k_nx_s;
            tiles_r <= tiles_nx_s;
            id_r    <= id_nx_s;
        end
    end

    // Next-state logic; abort outranks both stall and the done handshake.
    always_comb begin
        state_nx_s = state_r;
        t_nx_s     = t_r;
        k_nx_s     = k_r;
        tiles_nx_s = tiles_r;
        id_nx_s    = id_r;
        case (state_r)
            S_IDLE: begin
                if (host.job_valid) begin
                    id_nx_s    = host.job_id;
                    tiles_nx_s = host.job_tiles;
                    t_nx_s     = '0;
                    k_nx_s     = '0;
                    state_nx_s = (host.job_tiles != '0) ? S_LOAD : S_DONE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (host.abort) begin
                    state_nx_s = S_IDLE;
                    t_nx_s     = '0;
                    k_nx_s     = '0;
                end else if (!acc_ready_i) begin
                    state_nx_s = S_LOAD;
                end else if (t_r == T_LOAD_END) begin
                    state_nx_s = S_PROC;
                    t_nx_s     = '0;
                    k_nx_s     = '0;
                end else begin
                    t_nx_s = t_r + T_W'(1);
                end
            end
            S_PROC: begin
                if (host.abort) begin
                    state_nx_s = S_IDLE;
                    t_nx_s     = '0;
                    k_nx_s     = '0;
                end else if (!acc_ready_i) begin
                    state_nx_s = S_PROC;
                end else if (t_r == T_PROC_END) begin
                    t_nx_s = '0;
                    if (k_r != tiles_r - TILE_W'(1)) begin
                        k_nx_s = k_r + TILE_W'(1);
                    end else begin
                        k_nx_s     = '0;
                        state_nx_s = S_DONE;
                    end
                end else begin
                    t_nx_s = t_r + T_W'(1);
                end
            end
            S_DONE: begin
                if (host.abort || host.done_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                t_nx_s     = '0;
                k_nx_s     = '0;
            end
        endcase
    end

    // Moore output decode; stall only gates strobes, never addresses.
    always_comb begin
        mode_o          = PASSTHROUGH;
        array_en_o      = 1'b0;
        a_rd_en_o       = 1'b0;
        a_rd_addr_o     = '0;
        host.job_ready  = 1'b0;
        host.done_valid = 1'b0;
        host.done_id    = id_r;
        busy_o          = 1'b1;
        case (state_r)
            S_IDLE: begin
                host.job_ready = 1'b1;
                busy_o         = 1'b0;
            end
            S_LOAD: begin
                mode_o      = LOAD;
                array_en_o  = acc_ready_i;
                a_rd_en_o   = acc_ready_i;
                a_rd_addr_o = t_r[LOG_N-1:0];
            end
            S_PROC: begin
                mode_o     = PROCESS;
                array_en_o = acc_ready_i;
            end
            S_DONE: begin
                host.done_valid = 1'b1;
            end
            default: begin
                mode_o = PASSTHROUGH;
            end
        endcase
    end

    assign in_proc_s = (state_r == S_PROC);

    // Lane c reads B rows c..c+N-1 cycles into the pass; results emerge N-1 cycles later.
    for (genvar c = 0; c < N; c++) begin : g_lane
        localparam logic [T_W:0] B_LO = (T_W+1)'(c);
        localparam logic [T_W:0] V_LO = (T_W+1)'(N - 1 + c);
        localparam logic [T_W:0] SPAN = (T_W+1)'(N - 1);

        logic [T_W:0] b_off_s;
        logic [T_W:0] v_off_s;
        logic         b_win_s;
        logic         v_win_s;

        assign b_off_s = {1'b0, t_r} - B_LO;
        assign v_off_s = {1'b0, t_r} - V_LO;
        assign b_win_s = in_proc_s && (b_off_s <= SPAN);
        assign v_win_s = in_proc_s && (v_off_s <= SPAN);

        assign b_rd_en_o[c]   = b_win_s & acc_ready_i;
        assign acc_valid_o[c] = v_win_s & acc_ready_i;
        assign b_rd_addr_o[c] = b_win_s
                              ? (ADDR_W'(k_r) * ADDR_W'(N) + ADDR_W'(b_off_s))
                              : '0;
    end

endmodule
